// File: rtl/dpll_pkg.sv
// Shared types and defaults for the DPLL acquisition/lock sequencer.
package dpll_pkg;

  localparam int CODE_W_DEF   = 8;
  localparam int MID_CODE_DEF = 128;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAR_WAIT  = 3'd1,
    SAR_EVAL  = 3'd2,
    TRK_WAIT  = 3'd3,
    TRK_EVAL  = 3'd4,
    LOCK_WAIT = 3'd5,
    LOCK_EVAL = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

endpackage

// File: rtl/dpll_settle_timer.sv
// Settle down-counter: reloads while load is high, done once SETTLE_CYC cycles
// have elapsed since load dropped.
module dpll_settle_timer #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= LOAD_VAL;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL DCO code sequencer: SAR acquisition, then +/-1 tracking with lock
// qualification and drift-based unlock.
module dpll_lock_ctrl
  import dpll_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 3,
  parameter int MID_CODE   = MID_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              p_up,
  input  logic              p_down,
  output logic [CODE_W-1:0] code,
  output logic              lock,
  output logic              sar_done,
  output logic [2:0]        state_o
);

  localparam int IW  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int DCW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CODE_W-1:0] MID       = CODE_W'(MID_CODE);
  localparam logic [CODE_W-1:0] MAXC      = '1;
  localparam logic [IW-1:0]     TOP_BIT   = IW'(CODE_W - 1);
  localparam logic [LCW-1:0]    LOCK_MAX  = LCW'(LOCK_CNT);
  localparam logic [DCW-1:0]    DRIFT_MAX = DCW'(UNLOCK_CNT);

  function automatic logic [CODE_W-1:0] sat_step(input logic [CODE_W-1:0] c, input dir_t d);
    logic [CODE_W-1:0] r;
    r = c;
    if (d == DIR_UP && c != MAXC)      r = c + 1'b1;
    else if (d == DIR_DOWN && c != '0) r = c - 1'b1;
    return r;
  endfunction

  function automatic logic [LCW-1:0] sat_inc(input logic [LCW-1:0] v);
    return (v == LOCK_MAX) ? v : v + 1'b1;
  endfunction

  state_t            state, state_nx;
  dir_t              dir, last_dir, last_dir_nx;
  logic [CODE_W-1:0] code_nx;
  logic              lock_nx, sar_done_nx, sar_keep;
  logic [IW-1:0]     bit_idx, bit_idx_nx;
  logic [LCW-1:0]    lock_cnt, lock_cnt_nx, lock_cnt_upd;
  logic [DCW-1:0]    drift_cnt, drift_cnt_nx, drift_upd;
  logic              lock_hit, drift_hit, timer_load, timer_done;

  // Timer reloads in every non-wait state so each wait lasts exactly SETTLE_CYC cycles.
  assign timer_load = !(state inside {SAR_WAIT, TRK_WAIT, LOCK_WAIT});

  dpll_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  assign sar_keep = p_up && !p_down;

  always_comb begin
    dir = DIR_NONE;
    if (p_up && !p_down)      dir = DIR_UP;
    else if (p_down && !p_up) dir = DIR_DOWN;

    lock_cnt_upd = lock_cnt;
    if (dir == DIR_NONE || (last_dir != DIR_NONE && dir != last_dir))
      lock_cnt_upd = sat_inc(lock_cnt);
    else if (dir == last_dir)
      lock_cnt_upd = '0;

    drift_upd = '0;
    if (dir != DIR_NONE)
      drift_upd = (drift_cnt != '0 && dir == last_dir) ? drift_cnt + 1'b1 : DCW'(1);

    lock_hit  = (lock_cnt_upd == LOCK_MAX);
    drift_hit = (drift_upd == DRIFT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else begin
      case (state)
        IDLE:      state_nx = SAR_WAIT;
        SAR_WAIT:  if (timer_done) state_nx = SAR_EVAL;
        SAR_EVAL:  state_nx = (bit_idx == '0) ? TRK_WAIT : SAR_WAIT;
        TRK_WAIT:  if (timer_done) state_nx = TRK_EVAL;
        TRK_EVAL:  state_nx = lock_hit ? LOCK_WAIT : TRK_WAIT;
        LOCK_WAIT: if (timer_done) state_nx = LOCK_EVAL;
        LOCK_EVAL: state_nx = drift_hit ? TRK_WAIT : LOCK_WAIT;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    code_nx      = code;
    lock_nx      = lock;
    sar_done_nx  = 1'b0;
    bit_idx_nx   = bit_idx;
    lock_cnt_nx  = lock_cnt;
    drift_cnt_nx = drift_cnt;
    last_dir_nx  = last_dir;
    if (!enable) begin
      code_nx      = MID;
      lock_nx      = 1'b0;
      bit_idx_nx   = TOP_BIT;
      lock_cnt_nx  = '0;
      drift_cnt_nx = '0;
      last_dir_nx  = DIR_NONE;
    end else begin
      case (state)
        IDLE: begin
          code_nx    = MID;
          lock_nx    = 1'b0;
          bit_idx_nx = TOP_BIT;
        end
        SAR_EVAL: begin
          code_nx[bit_idx] = sar_keep;
          if (bit_idx != '0) begin
            code_nx[bit_idx - 1'b1] = 1'b1;
            bit_idx_nx = bit_idx - 1'b1;
          end else begin
            sar_done_nx = 1'b1;
          end
        end
        TRK_EVAL, LOCK_EVAL: begin
          code_nx     = sat_step(code, dir);
          lock_cnt_nx = lock_cnt_upd;
          if (dir != DIR_NONE) last_dir_nx = dir;
          if (state == TRK_EVAL) begin
            drift_cnt_nx = '0;
            if (lock_hit) lock_nx = 1'b1;
          end else begin
            drift_cnt_nx = drift_upd;
            // Sustained drift: drop lock but keep the corrected code, no re-SAR.
            if (drift_hit) begin
              lock_nx      = 1'b0;
              lock_cnt_nx  = '0;
              drift_cnt_nx = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code      <= MID;
      lock      <= 1'b0;
      sar_done  <= 1'b0;
      bit_idx   <= TOP_BIT;
      lock_cnt  <= '0;
      drift_cnt <= '0;
      last_dir  <= DIR_NONE;
    end else begin
      code      <= code_nx;
      lock      <= lock_nx;
      sar_done  <= sar_done_nx;
      bit_idx   <= bit_idx_nx;
      lock_cnt  <= lock_cnt_nx;
      drift_cnt <= drift_cnt_nx;
      last_dir  <= last_dir_nx;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Directed bench for dpll_lock_ctrl with a phase-detector model driven by a target code.
module tb_dpll_lock_ctrl;
  import dpll_pkg::*;

  logic       clk = 1'b0;
  logic       rst, enable, p_up, p_down;
  logic [7:0] code;
  logic       lock, sar_done;
  logic [2:0] state_o;

  int  tgt = 0;
  bit  alt_mode = 1'b0;
  int  cyc = 0;
  int  errs = 0;
  int  checks = 0;
  logic [31:0] exp_q[$];

  dpll_lock_ctrl #(
    .CODE_W(8), .SETTLE_CYC(4), .LOCK_CNT(8), .UNLOCK_CNT(3), .MID_CODE(128)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .p_up(p_up), .p_down(p_down),
    .code(code), .lock(lock), .sar_done(sar_done), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Phase detector model: compares the DCO code against the target.
  always_comb begin
    p_up   = alt_mode ? (int'(code) <= tgt) : (int'(code) < tgt);
    p_down = (int'(code) > tgt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++; errs++;
      $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic timeout(input string tag, input int budget);
    checks++; errs++;
    $error("FAIL %s: timed out after %0d cycles, observed=0 expected=1", tag, budget);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (state_o !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_o !== st) timeout(tag, budget);
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int n = 0;
    while (lock !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (lock !== 1'b1) timeout(tag, budget);
  endtask

  task automatic wait_sar_done(input string tag, input int budget);
    int n = 0;
    while (sar_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sar_done !== 1'b1) timeout(tag, budget);
  endtask

  initial begin
    int en_edge, sd_cyc, t0, lock_hi;
    bit sd_seen;
    logic [7:0] trials [8];

    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code",     32'(code),     32'h80);
    check("rst_lock",     32'(lock),     32'h0);
    check("rst_sar_done", 32'(sar_done), 32'h0);
    check("rst_state",    32'(state_o),  32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(state_o), 32'(IDLE));

    // Acquisition toward 0xA5
    tgt = 'hA5; alt_mode = 1'b0;
    trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    foreach (trials[k]) exp_q.push_back(32'(trials[k]));
    enable = 1'b1;
    en_edge = cyc + 1;
    sd_seen = 1'b0; sd_cyc = 0;
    for (int n = 0; n < 60 && !sd_seen; n++) begin
      @(negedge clk);
      if (sar_done === 1'b1) begin
        sd_seen = 1'b1;
        sd_cyc = cyc;
      end else if (state_o == SAR_EVAL) begin
        check_pop("sar_trial", 32'(code));
      end
    end
    if (!sd_seen) timeout("sar_done", 60);
    check("sar_trials_left",  32'(exp_q.size()),    32'd0);
    check("sar_final_code",   32'(code),            32'hA4);
    check("sar_done_latency", 32'(sd_cyc - en_edge), 32'd40);
    @(negedge clk);
    check("sar_done_pulse", 32'(sar_done), 32'h0);

    wait_state("first_trk_eval", TRK_EVAL, 10);
    @(negedge clk);
    check("first_trk_code", 32'(code), 32'hA5);
    check("first_trk_lock", 32'(lock), 32'h0);
    t0 = cyc;
    wait_lock("lock_a5", 100);
    check("lock_latency", 32'(cyc - t0), 32'd40);
    check("lock_state",   32'(state_o),  32'(LOCK_WAIT));
    check("lock_code",    32'(code),     32'hA5);

    // Target jumps to 0xB0: three UP corrections drop lock
    tgt = 'hB0;
    exp_q.push_back(32'hA6); exp_q.push_back(32'hA7); exp_q.push_back(32'hA8);
    for (int k = 0; k < 3; k++) begin
      wait_state("drift_eval", LOCK_EVAL, 10);
      @(negedge clk);
      check_pop("drift_code", 32'(code));
      check("drift_lock", 32'(lock), (k < 2) ? 32'h1 : 32'h0);
    end
    check("unlock_state", 32'(state_o), 32'(TRK_WAIT));
    t0 = cyc;
    wait_lock("relock_b0", 150);
    check("relock_code",    32'(code),       32'hB0);
    check("relock_latency", 32'(cyc - t0),   32'd80);

    // Target above full scale: code pins at 0xFF, never locks
    enable = 1'b0;
    @(negedge clk);
    check("disable_state", 32'(state_o), 32'(IDLE));
    check("disable_code",  32'(code),    32'h80);
    check("disable_lock",  32'(lock),    32'h0);
    tgt = 256;
    enable = 1'b1;
    wait_sar_done("sat_sar", 60);
    check("sat_sar_code", 32'(code), 32'hFF);
    lock_hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (lock === 1'b1) lock_hi++;
    end
    check("sat_no_lock", 32'(lock_hi), 32'd0);
    check("sat_code",    32'(code),    32'hFF);

    // Alternating flags: reversals qualify lock
    enable = 1'b0;
    @(negedge clk);
    tgt = 'h5A; alt_mode = 1'b1;
    enable = 1'b1;
    wait_sar_done("alt_sar", 60);
    check("alt_sar_code", 32'(code), 32'h5A);
    for (int n = 1; n <= 9; n++) exp_q.push_back((n % 2 == 1) ? 32'h5B : 32'h5A);
    for (int n = 1; n <= 9; n++) begin
      wait_state("alt_eval", TRK_EVAL, 10);
      @(negedge clk);
      check_pop("alt_code", 32'(code));
      check("alt_lock", 32'(lock), (n == 9) ? 32'h1 : 32'h0);
    end

    // Abort mid-SAR while bit 4 is on trial
    enable = 1'b0;
    @(negedge clk);
    tgt = 'hA5; alt_mode = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_state("abort_eval", SAR_EVAL, 10);
      @(negedge clk);
    end
    check("abort_trial", 32'(code), 32'hB0);
    enable = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state_o), 32'(IDLE));
    check("abort_code",  32'(code),    32'h80);
    enable = 1'b1;
    exp_q.push_back(32'h80); exp_q.push_back(32'hC0);
    for (int k = 0; k < 2; k++) begin
      wait_state("restart_eval", SAR_EVAL, 10);
      check_pop("restart_trial", 32'(code));
      @(negedge clk);
    end

    // Asynchronous reset while locked, off the clock edge
    wait_lock("lock_before_rst", 200);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_lock",  32'(lock),    32'h0);
    check("arst_code",  32'(code),    32'h80);
    check("arst_state", 32'(state_o), 32'(IDLE));
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dpll_lock_ctrl.md
Name: dpll_lock_ctrl

Overview:
Acquisition and lock sequencer for the DPLL DCO control code. After enable, a successive-approximation (SAR) search on the 8-bit DCO code is driven by the phase-detector up/down flags. The block then switches to linear ±1 tracking and asserts lock once the loop settles. It feeds the code/lock inputs of the averaging filter and drops lock on sustained one-directional drift.

Parameters:
CODE_W, 8, DCO code width
SETTLE_CYC, 4, clk cycles waited after every code change before phase flags are sampled (≥1)
LOCK_CNT, 8, qualifying evaluations required to declare lock (≥1, ≤255)
UNLOCK_CNT, 3, consecutive same-direction corrections in LOCKED that drop lock (≥2)
MID_CODE, 128, code driven in reset/IDLE

Ports:
clk  input  1  reference-domain clock; one phase-detector result per cycle
rst  input  1  reset, asynchronous, active-high
enable  input  1  start/hold acquisition; low forces IDLE
p_up  input  1  DCO slow, raise code; already synchronous to clk
p_down  input  1  DCO fast, lower code; already synchronous to clk
code  output  CODE_W  DCO control code, registered
lock  output  1  loop locked, registered
sar_done  output  1  one-cycle pulse on SAR completion
state_o  output  3  current FSM state, for debug

Behaviour:
- Reset: code=MID_CODE, lock=0, sar_done=0, state=IDLE, all counters 0, last_dir=NONE.
- IDLE: code=MID_CODE, lock=0. When enable=1, go to SAR_WAIT with bit index i=CODE_W-1 and code=MID_CODE (trial 0x80).
- SAR_WAIT: settle timer counts SETTLE_CYC cycles, then go to SAR_EVAL.
- SAR_EVAL, one cycle:
  - Keep bit i only if p_up=1 and p_down=0. Otherwise clear it, including both=1 and both=0.
  - If i>0: set bit i-1, decrement i, reenter SAR_WAIT.
  - If i==0: pulse sar_done, go to TRK_WAIT.
  - Cost is SETTLE_CYC+1 cycles per bit, so 40 cycles for 8 bits at the default.
- TRK_WAIT: wait SETTLE_CYC cycles, then go to TRK_EVAL.
- TRK_EVAL, one cycle:
  - dir = UP if up-only, DOWN if down-only, else NONE.
  - UP: code+1, saturating at 2^CODE_W-1.
  - DOWN: code-1, saturating at 0.
  - NONE: code unchanged.
  - A saturated step still counts as a correction in that direction.
- lock_cnt:
  - +1 on NONE, or on a direction opposite to last_dir (reversal).
  - Reset to 0 when dir equals last_dir (both UP or both DOWN).
  - No change when last_dir=NONE and dir is UP or DOWN.
- last_dir is updated only on non-NONE evaluations.
- Lock entry: when lock_cnt reaches LOCK_CNT, set lock=1 on the same clock edge and go to LOCKED. lock_cnt saturates, never wraps.
- LOCKED: same WAIT/EVAL cadence and same code update as tracking.
- drift_cnt:
  - Counts consecutive same-direction corrections, starting at 1 on the first one.
  - Reset by NONE or a reversal.
  - When drift_cnt reaches UNLOCK_CNT: lock=0, lock_cnt=0, drift_cnt=0, go to TRK_WAIT. Code keeps its updated value; no re-SAR.
- enable=0 in any state: next cycle go to IDLE, code=MID_CODE, lock=0, counters cleared. An aborted SAR restarts from bit 7 on the next enable.
- Async rst mid-operation returns immediately to reset values.
- Phase flags are ignored outside EVAL cycles.

Decomposition:
- Shared package dpll_pkg holds:
  - state enum: IDLE, SAR_WAIT, SAR_EVAL, TRK_WAIT, TRK_EVAL, LOCK_WAIT, LOCK_EVAL (3 bits)
  - dir encoding: NONE/UP/DOWN
  - MID_CODE and CODE_W defaults
- Sub-module dpll_settle_timer: load/count/done down-counter sized from SETTLE_CYC, instantiated once.

Test Plan:
- Reset, then enable=1; bench model p_up=(code<0xA5), p_down=(code>0xA5). Required:
  - Trial sequence 80,C0,A0,B0,A8,A4,A6,A5.
  - Final SAR code 0xA4, with sar_done pulsed 40 cycles after enable.
  - First track step to 0xA5.
  - lock=1 after 8 further NONE evaluations (40 cycles).
- Locked at 0xA5, target moves to 0xB0. Required: codes A6, A7, A8 and lock drops at the third UP eval. Tracking then continues to 0xB0 and relocks.
- Target above 0xFF (p_up stuck). Required:
  - SAR yields 0xFF and code saturates at 0xFF.
  - lock never asserts, because lock_cnt resets on every repeated UP.
- Alternating flags every eval (up, down, up, ...) after SAR. Required: lock asserts after 8 reversals; code oscillates by ±1.
- Deassert enable mid-SAR at bit 4. Required: IDLE next cycle with code=0x80. Re-enable restarts the trial sequence at 0x80.
- Assert async rst during LOCKED, not aligned to clk. Required: lock=0 and code=0x80 immediately, state=IDLE.
